data_receiver: RTL

DATA_RECEIVER -- requirements
Module: data_receiver

---
 rtl/data_receiver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/data_receiver.sv
// rtl/data_receiver.sv - 8O1 serial frame receiver with parity and framing checks
//
// Receives frames of: start bit 0, eight data bits LSB first, one odd-parity
// bit, stop bit 1. The line is sampled at the centre of each bit period.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   serial_in    serial line, idles high
//   data_out     last received byte (held until the next frame completes)
//   data_valid   one-clock pulse when a frame completes
//   parity_error odd-parity check failed on the last frame
//   frame_error  stop bit of the last frame was sampled low
//   busy         a frame is in progress
module data_receiver #(
  parameter int CLKS_PER_BIT = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par_run, par_run_nx;
  logic          par_bit, par_bit_nx;
  logic [7:0]    data_out_nx;
  logic          data_valid_nx, parity_error_nx, frame_error_nx;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync         <= 2'b11;
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_run      <= 1'b0;
      par_bit      <= 1'b0;
      data_out     <= 8'h00;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sync         <= {sync[0], serial_in};
      state        <= state_nx;
      cnt          <= cnt_nx;
      bit_idx      <= bit_idx_nx;
      shreg        <= shreg_nx;
      par_run      <= par_run_nx;
      par_bit      <= par_bit_nx;
      data_out     <= data_out_nx;
      data_valid   <= data_valid_nx;
      parity_error <= parity_error_nx;
      frame_error  <= frame_error_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    bit_idx_nx      = bit_idx;
    shreg_nx        = shreg;
    par_run_nx      = par_run;
    par_bit_nx      = par_bit;
    data_out_nx     = data_out;
    data_valid_nx   = 1'b0;
    parity_error_nx = parity_error;
    frame_error_nx  = frame_error;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx   = START;
          cnt_nx     = '0;
          par_run_nx = 1'b0;
        end
      end

      // Half a bit period lands the sample point in the middle of the start
      // bit; every later sample is then one full period further on.
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx            = '0;
          shreg_nx[bit_idx] = rx_s;
          par_run_nx        = par_run ^ rx_s;
          bit_idx_nx        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = PARITY;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nx     = '0;
          par_bit_nx = rx_s;
          state_nx   = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      // Returning to IDLE at the mid-stop sample leaves half a bit period to
      // catch the next start bit when frames are sent back to back.
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nx          = '0;
          state_nx        = IDLE;
          data_valid_nx   = 1'b1;
          data_out_nx     = shreg;
          parity_error_nx = ~(par_run ^ par_bit);
          frame_error_nx  = ~rx_s;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
